// File: rtl/tdes_pass_sequencer.sv
// Drives one shared iterative DES core through the three EDE/DED passes of a
// Triple-DES block, choosing key and direction per pass, with a per-pass watchdog.
module tdes_pass_sequencer #(
  parameter int THREE_KEY = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        e,
  input  logic [63:0] intext,
  input  logic [55:0] key1,
  input  logic [55:0] key2,
  input  logic [55:0] key3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] password,
  output logic        out_err,
  output logic        des_start,
  output logic [63:0] des_in,
  output logic [55:0] des_k,
  output logic        des_e,
  input  logic        des_done,
  input  logic [63:0] des_out,
  output logic [1:0]  pass_idx
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  localparam bit          USE_KEY3 = (THREE_KEY != 0);
  localparam bit          WDOG_EN  = (TIMEOUT > 0);
  localparam logic [31:0] TMO      = 32'(TIMEOUT);

  state_t      state_q, state_d;
  logic [63:0] work_q, work_d;
  logic [55:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic        e_q, e_d;
  logic [1:0]  pass_q, pass_d;
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [15:0] wdog_inc;
  logic        wdog_fire;
  logic [55:0] tkey;
  logic [55:0] kmux;
  logic        emux;
  logic        busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      e_q     <= 1'b0;
      pass_q  <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
      e_q     <= e_d;
      pass_q  <= pass_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // The launch cycle counts as the first cycle of a pass, so the watchdog
  // fires exactly TIMEOUT cycles after des_start.
  assign wdog_inc  = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
  assign wdog_fire = WDOG_EN && ({16'd0, wdog_inc} >= TMO);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT: begin
        if (done_q)         state_d = (pass_q == 2'd2) ? DONE : LAUNCH;
        else if (wdog_fire) state_d = DONE;
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // des_done is only captured in WAIT; the transition acts on the registered
  // copy, which also keeps a pulse in the LAUNCH cycle from counting.
  always_comb begin
    work_d = work_q;
    k1_d   = k1_q;
    k2_d   = k2_q;
    k3_d   = k3_q;
    e_d    = e_q;
    pass_d = pass_q;
    wdog_d = wdog_q;
    err_d  = err_q;
    done_d = des_done && (state_q == WAIT) && !done_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = intext;
          k1_d   = key1;
          k2_d   = key2;
          k3_d   = key3;
          e_d    = e;
          pass_d = 2'd0;
          err_d  = 1'b0;
        end
      end
      LAUNCH: wdog_d = 16'd1;
      WAIT: begin
        wdog_d = wdog_inc;
        if (des_done && !done_q) work_d = des_out;
        if (done_q) begin
          if (pass_q != 2'd2) pass_d = pass_q + 2'd1;
        end else if (wdog_fire) begin
          err_d = 1'b1;
        end
      end
      DONE: if (out_ready) err_d = 1'b0;
      default: ;
    endcase
  end

  assign tkey = USE_KEY3 ? k3_q : k1_q;

  always_comb begin
    case (pass_q)
      2'd0:    kmux = e_q ? k1_q : tkey;
      2'd1:    kmux = k2_q;
      default: kmux = e_q ? tkey : k1_q;
    endcase
    emux = (pass_q == 2'd1) ? !e_q : e_q;
  end

  always_comb begin
    busy      = (state_q == LAUNCH) || (state_q == WAIT);
    in_ready  = (state_q == IDLE);
    des_start = (state_q == LAUNCH);
    des_in    = busy ? work_q : 64'd0;
    des_k     = busy ? kmux : 56'd0;
    des_e     = busy && emux;
    out_valid = (state_q == DONE);
    out_err   = (state_q == DONE) && err_q;
    password  = ((state_q == DONE) && !err_q) ? work_q : 64'd0;
    pass_idx  = (state_q == IDLE) ? 2'd0 : pass_q;
  end

endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// Directed bench: two sequencers (two-key and three-key) each driving an
// adder/subtractor stand-in for the DES core with a fixed 3-cycle latency.
module tb_tdes_pass_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        e;
  logic [63:0] intext;
  logic [55:0] key1, key2, key3;
  logic        out_ready;
  logic [1:0]  in_valid, in_ready, out_valid, out_err, des_start, des_e, des_done;
  logic [1:0]  mute, spur;
  logic [63:0] password [2];
  logic [63:0] des_in [2];
  logic [63:0] des_out [2];
  logic [55:0] des_k [2];
  logic [1:0]  pass_idx [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tdes_pass_sequencer #(.THREE_KEY(0), .TIMEOUT(64)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .e(e), .intext(intext), .key1(key1), .key2(key2), .key3(key3),
    .out_valid(out_valid[0]), .out_ready(out_ready), .password(password[0]),
    .out_err(out_err[0]), .des_start(des_start[0]), .des_in(des_in[0]),
    .des_k(des_k[0]), .des_e(des_e[0]), .des_done(des_done[0]),
    .des_out(des_out[0]), .pass_idx(pass_idx[0]));

  tdes_pass_sequencer #(.THREE_KEY(1), .TIMEOUT(64)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .e(e), .intext(intext), .key1(key1), .key2(key2), .key3(key3),
    .out_valid(out_valid[1]), .out_ready(out_ready), .password(password[1]),
    .out_err(out_err[1]), .des_start(des_start[1]), .des_in(des_in[1]),
    .des_k(des_k[1]), .des_e(des_e[1]), .des_done(des_done[1]),
    .des_out(des_out[1]), .pass_idx(pass_idx[1]));

  // Core stand-in: des_done three cycles after des_start; not reset on purpose.
  logic [1:0]  scnt [2] = '{default: 2'd0};
  logic [63:0] sin  [2] = '{default: 64'd0};
  logic [55:0] sk   [2] = '{default: 56'd0};
  logic        se   [2] = '{default: 1'b0};

  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (des_start[i]) begin
        scnt[i] <= 2'd3;
        sin[i]  <= des_in[i];
        sk[i]   <= des_k[i];
        se[i]   <= des_e[i];
      end else if (scnt[i] != 2'd0) begin
        scnt[i] <= scnt[i] - 2'd1;
      end
    end

  always_comb begin
    des_done = '0;
    for (int i = 0; i < 2; i++) begin
      des_done[i] = ((scnt[i] == 2'd1) && !mute[i]) || spur[i];
      des_out[i]  = se[i] ? sin[i] + {8'd0, sk[i]} : sin[i] - {8'd0, sk[i]};
    end
  end

  // Log of every pass launch: input block, key, direction, launch cycle.
  logic [63:0] lg_in [2][32];
  logic [55:0] lg_k  [2][32];
  logic        lg_e  [2][32];
  int          lg_n   [2] = '{0, 0};
  int          st_cyc [2] = '{0, 0};

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (des_start[i]) begin
        lg_in[i][lg_n[i][4:0]] <= des_in[i];
        lg_k[i][lg_n[i][4:0]]  <= des_k[i];
        lg_e[i][lg_n[i][4:0]]  <= des_e[i];
        lg_n[i]   <= lg_n[i] + 1;
        st_cyc[i] <= cyc;
      end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic ee, input logic [63:0] t,
                      input logic [55:0] a, input logic [55:0] b, input logic [55:0] c);
    chk($sformatf("in_ready_before_send%0d", i), 64'(in_ready[i]), 64'd1);
    e = ee; intext = t; key1 = a; key2 = b; key3 = c;
    in_valid[i] = 1'b1;
    tick();
    in_valid[i] = 1'b0;
  endtask

  // n counts clock edges from the accept edge (which is edge 1).
  task automatic wait_out(input int i, input int n0, input string tag, output int n);
    n = n0;
    while (!out_valid[i] && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_out_valid"}, 64'(out_valid[i]), 64'd1);
  endtask

  task automatic chk_passes(input int i, input int base, input string tag,
                            input logic [63:0] i0, input logic [63:0] i1, input logic [63:0] i2,
                            input logic [55:0] k0, input logic [55:0] k1, input logic [55:0] k2,
                            input logic e0, input logic e1, input logic e2);
    logic [63:0] xi [3];
    logic [55:0] xk [3];
    logic        xe [3];
    logic [4:0]  idx;
    xi = '{i0, i1, i2};
    xk = '{k0, k1, k2};
    xe = '{e0, e1, e2};
    chk({tag, "_npass"}, 64'(lg_n[i] - base), 64'd3);
    for (int p = 0; p < 3; p++) begin
      idx = 5'(base + p);
      chk($sformatf("%s_des_in%0d", tag, p), lg_in[i][idx], xi[p]);
      chk($sformatf("%s_des_k%0d", tag, p), 64'(lg_k[i][idx]), 64'(xk[p]));
      chk($sformatf("%s_des_e%0d", tag, p), 64'(lg_e[i][idx]), 64'(xe[p]));
    end
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid[i]), 64'd0);
    chk({tag, "_out_err"},   64'(out_err[i]),   64'd0);
    chk({tag, "_des_start"}, 64'(des_start[i]), 64'd0);
    chk({tag, "_des_in"},    des_in[i],         64'd0);
    chk({tag, "_des_k"},     64'(des_k[i]),     64'd0);
    chk({tag, "_des_e"},     64'(des_e[i]),     64'd0);
    chk({tag, "_password"},  password[i],       64'd0);
    chk({tag, "_pass_idx"},  64'(pass_idx[i]),  64'd0);
  endtask

  initial begin
    int base;
    int n;
    int k;
    rst_n = 1'b0; e = 1'b0; intext = '0; key1 = '0; key2 = '0; key3 = '0;
    out_ready = 1'b1; in_valid = '0; mute = '0; spur = '0;

    // Reset state
    #12;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready0", 64'(in_ready[0]), 64'd1);
    chk("rst_in_ready1", 64'(in_ready[1]), 64'd1);

    // 1: encrypt, two-key (key3 must be ignored)
    base = lg_n[0];
    send(0, 1'b1, 64'h10, 56'd1, 56'd2, 56'h77);
    chk("t1_des_start", 64'(des_start[0]), 64'd1);
    chk("t1_pass_idx0", 64'(pass_idx[0]), 64'd0);
    wait_out(0, 1, "t1", n);
    chk("t1_latency", 64'(n), 64'd16);
    chk("t1_password", password[0], 64'h10);
    chk("t1_out_err", 64'(out_err[0]), 64'd0);
    chk_passes(0, base, "t1", 64'h10, 64'h11, 64'hF, 56'd1, 56'd2, 56'd1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("t1_out_valid_clr", 64'(out_valid[0]), 64'd0);
    chk("t1_in_ready_back", 64'(in_ready[0]), 64'd1);

    // 2: decrypt, three-key
    base = lg_n[1];
    send(1, 1'b0, 64'h100, 56'd1, 56'd2, 56'd4);
    wait_out(1, 1, "t2", n);
    chk("t2_latency", 64'(n), 64'd16);
    chk("t2_password", password[1], 64'hFD);
    chk_passes(1, base, "t2", 64'h100, 64'hFC, 64'hFE, 56'd4, 56'd2, 56'd1, 1'b0, 1'b1, 1'b0);
    tick();

    // 3: backpressure in DONE, then a second block
    out_ready = 1'b0;
    send(0, 1'b0, 64'h50, 56'd3, 56'd5, 56'd9);
    wait_out(0, 1, "t3", n);
    chk("t3_password", password[0], 64'h4F);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t3_hold_valid%0d", c), 64'(out_valid[0]), 64'd1);
      chk($sformatf("t3_hold_pw%0d", c), password[0], 64'h4F);
      chk($sformatf("t3_hold_ready%0d", c), 64'(in_ready[0]), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_out_valid_clr", 64'(out_valid[0]), 64'd0);
    chk("t3_in_ready_back", 64'(in_ready[0]), 64'd1);
    send(0, 1'b1, 64'h20, 56'd3, 56'd4, 56'd0);
    wait_out(0, 1, "t3b", n);
    chk("t3b_latency", 64'(n), 64'd16);
    chk("t3b_password", password[0], 64'h22);
    tick();

    // 4: watchdog, core never answers
    mute[0] = 1'b1;
    base = lg_n[0];
    send(0, 1'b1, 64'h10, 56'd1, 56'd2, 56'd0);
    wait_out(0, 1, "t4", n);
    chk("t4_cycles_from_start", 64'(cyc - st_cyc[0]), 64'd64);
    chk("t4_npass", 64'(lg_n[0] - base), 64'd1);
    chk("t4_out_err", 64'(out_err[0]), 64'd1);
    chk("t4_password", password[0], 64'd0);
    tick();
    chk("t4_out_valid_clr", 64'(out_valid[0]), 64'd0);
    chk("t4_out_err_clr", 64'(out_err[0]), 64'd0);
    mute[0] = 1'b0;
    tick();

    // 5: reset during pass 1, stale des_done arrives while idle
    base = lg_n[0];
    send(0, 1'b1, 64'h10, 56'd1, 56'd2, 56'd0);
    k = 0;
    while (lg_n[0] < base + 2 && k < 100) begin
      tick();
      k++;
    end
    chk("t5_reached_pass1", 64'(lg_n[0] - base), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_zero(0, "t5_rst");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_idle_ready", 64'(in_ready[0]), 64'd1);
    chk("t5_idle_valid", 64'(out_valid[0]), 64'd0);
    chk("t5_idle_pass", 64'(pass_idx[0]), 64'd0);
    send(0, 1'b0, 64'h50, 56'd3, 56'd5, 56'd0);
    wait_out(0, 1, "t5", n);
    chk("t5_latency", 64'(n), 64'd16);
    chk("t5_password", password[0], 64'h4F);
    tick();

    // 6: spurious des_done in IDLE and LAUNCH, inputs change mid-run
    spur[0] = 1'b1;
    tick();
    spur[0] = 1'b0;
    chk("t6_idle_ready", 64'(in_ready[0]), 64'd1);
    chk("t6_idle_valid", 64'(out_valid[0]), 64'd0);
    chk("t6_idle_start", 64'(des_start[0]), 64'd0);
    base = lg_n[0];
    send(0, 1'b0, 64'h3C, 56'd5, 56'd7, 56'd0);
    chk("t6_in_launch", 64'(des_start[0]), 64'd1);
    spur[0] = 1'b1;
    e = 1'b1; intext = 64'hFFFF; key1 = 56'hAA; key2 = 56'hBB; key3 = 56'hCC;
    tick();
    spur[0] = 1'b0;
    wait_out(0, 2, "t6", n);
    chk("t6_latency", 64'(n), 64'd16);
    chk("t6_password", password[0], 64'h39);
    chk_passes(0, base, "t6", 64'h3C, 64'h37, 64'h3E, 56'd5, 56'd7, 56'd5, 1'b0, 1'b1, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
